// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences a raster pixel stream into KERNEL_WIDTH+1 line buffers and walks K x K window positions.
// Latency: the edge writing the last pixel of a needed line makes the window valid in the next cycle; window data is combinational from the buffers.
// Backpressure: pixel_ready_o drops when every buffer holds an unread line or the frame's pixels are all in; windows hold until window_ready_i.
//
// Ports:
//   clk_i, resetn_i                 single clock, asynchronous active-low reset
//   start_i, abort_i                frame start (IDLE only, dimension checked) and frame cancel (highest priority)
//   image_dimension                 square image side, latched on an accepted start
//   pixel_valid_i / pixel_ready_o   input pixel handshake; buf_we_o is the one-hot write strobe into buffer wr_sel
//   buf_clear_n_o                   buffer clear, low while idle
//   read_address_o, row_sel_o       shared column address and top-row buffer index of the current window
//   window_valid_o / window_ready_i window handshake with window_row_o, window_col_o, window_last_o
//   frame_done_o, busy_o            end-of-frame pulse and non-idle flag
// Optional build macro CONV_WINDOW_CTRL_STALL_CNT_EN adds saturating in_stall_cnt_o / out_stall_cnt_o.
module conv_window_ctrl #(
    parameter int  KERNEL_WIDTH   = 3,
    parameter int  MAX_LINE_WIDTH = 32,
    localparam int NB             = KERNEL_WIDTH + 1,
    localparam int AW             = $clog2(MAX_LINE_WIDTH),
    localparam int SW             = $clog2(NB)
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] image_dimension,
    input  logic          pixel_valid_i,
    output logic          pixel_ready_o,
    output logic [NB-1:0] buf_we_o,
    output logic          buf_clear_n_o,
    output logic [AW-1:0] read_address_o,
    output logic [SW-1:0] row_sel_o,
    output logic          window_valid_o,
    input  logic          window_ready_i,
    output logic [AW-1:0] window_row_o,
    output logic [AW-1:0] window_col_o,
    output logic          window_last_o,
    output logic          frame_done_o,
    output logic          busy_o
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   in_stall_cnt_o,
    output logic [15:0]   out_stall_cnt_o
`endif
);

    localparam int LW = $clog2(NB + 1);
    localparam int PW = 2 * AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [AW:0]   DIM_MIN    = (AW+1)'(KERNEL_WIDTH);
    localparam logic [AW:0]   DIM_MAX    = (AW+1)'(MAX_LINE_WIDTH);
    localparam logic [AW-1:0] K_AW       = AW'(KERNEL_WIDTH);
    localparam logic [LW-1:0] LINES_FULL = LW'(NB);
    localparam logic [LW-1:0] LINES_WIN  = LW'(KERNEL_WIDTH);
    localparam logic [SW-1:0] SEL_LAST   = SW'(NB - 1);

    logic [1:0]    state_q;
    logic [AW-1:0] dim_q;
    logic [AW-1:0] wr_col_q;
    logic [AW-1:0] rd_col_q;
    logic [AW-1:0] win_row_q;
    logic [PW-1:0] wr_pix_q;
    logic [SW-1:0] wr_sel_q;
    logic [SW-1:0] row_sel_q;
    // Number of buffers holding a complete, not yet released line.
    logic [LW-1:0] lines_q;

    logic          active;
    logic          start_ok;
    logic          wr_fire;
    logic          rd_fire;
    logic          line_done;
    logic          row_done;
    logic [AW-1:0] dim_m1;
    logic [AW-1:0] last_pos;
    logic [PW-1:0] pix_total;

    function automatic logic [SW-1:0] next_sel(input logic [SW-1:0] sel);
        return (sel == SEL_LAST) ? '0 : sel + SW'(1);
    endfunction

    assign active    = (state_q == ST_ACTIVE);
    assign dim_m1    = dim_q - AW'(1);
    assign last_pos  = dim_q - K_AW;
    assign pix_total = PW'(dim_q) * PW'(dim_q);

    assign start_ok = start_i
                   && ({1'b0, image_dimension} >= DIM_MIN)
                   && ({1'b0, image_dimension} <= DIM_MAX);

    // With lines_q < NB the buffer at wr_sel is never one of the K being read.
    assign pixel_ready_o = active && (lines_q < LINES_FULL) && (wr_pix_q < pix_total);
    assign wr_fire       = pixel_valid_i && pixel_ready_o;
    assign line_done     = wr_fire && (wr_col_q == dim_m1);
    assign buf_we_o      = wr_fire ? (NB'(1) << wr_sel_q) : '0;

    assign window_valid_o = active && (lines_q >= LINES_WIN);
    assign rd_fire        = window_valid_o && window_ready_i;
    assign row_done       = rd_fire && (rd_col_q == last_pos);
    // Gated by ACTIVE so a small latched dimension cannot raise it while idle.
    assign window_last_o  = active && (win_row_q == last_pos) && (rd_col_q == last_pos);

    assign read_address_o = rd_col_q;
    assign window_col_o   = rd_col_q;
    assign window_row_o   = win_row_q;
    assign row_sel_o      = row_sel_q;
    assign buf_clear_n_o  = (state_q != ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_done_o   = (state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= ST_IDLE;
            dim_q     <= '0;
            wr_col_q  <= '0;
            rd_col_q  <= '0;
            win_row_q <= '0;
            wr_pix_q  <= '0;
            wr_sel_q  <= '0;
            row_sel_q <= '0;
            lines_q   <= '0;
        end else if (abort_i || (state_q == ST_DONE)) begin
            // Every path into IDLE leaves the sequencing state cleared.
            state_q   <= ST_IDLE;
            wr_col_q  <= '0;
            rd_col_q  <= '0;
            win_row_q <= '0;
            wr_pix_q  <= '0;
            wr_sel_q  <= '0;
            row_sel_q <= '0;
            lines_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (start_ok) begin
                state_q <= ST_ACTIVE;
                dim_q   <= image_dimension;
            end
        end else if (active) begin
            if (wr_fire) begin
                wr_pix_q <= wr_pix_q + PW'(1);
                if (line_done) begin
                    wr_col_q <= '0;
                    wr_sel_q <= next_sel(wr_sel_q);
                end else begin
                    wr_col_q <= wr_col_q + AW'(1);
                end
            end
            if (rd_fire) begin
                if (row_done) begin
                    rd_col_q  <= '0;
                    row_sel_q <= next_sel(row_sel_q);
                    win_row_q <= win_row_q + AW'(1);
                end else begin
                    rd_col_q <= rd_col_q + AW'(1);
                end
            end
            // A completed line and a released row in the same cycle cancel out.
            if (line_done && !row_done) begin
                lines_q <= lines_q + LW'(1);
            end else if (!line_done && row_done) begin
                lines_q <= lines_q - LW'(1);
            end
            if (rd_fire && window_last_o) begin
                state_q <= ST_DONE;
            end
        end else begin
            state_q <= ST_IDLE;
        end
    end

`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic start_acc;
    assign start_acc = (state_q == ST_IDLE) && !abort_i && start_ok;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            in_stall_cnt_o  <= '0;
            out_stall_cnt_o <= '0;
        end else if (start_acc) begin
            in_stall_cnt_o  <= '0;
            out_stall_cnt_o <= '0;
        end else begin
            if (active && pixel_valid_i && !pixel_ready_o && (in_stall_cnt_o != 16'hFFFF)) begin
                in_stall_cnt_o <= in_stall_cnt_o + 16'd1;
            end
            if (active && window_valid_o && !window_ready_i && (out_stall_cnt_o != 16'hFFFF)) begin
                out_stall_cnt_o <= out_stall_cnt_o + 16'd1;
            end
        end
    end
`else
    // Stall instrumentation not built.
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: window positions are queued at each start and popped on every window handshake.
module tb_conv_window_ctrl;

    localparam int K  = 3;
    localparam int NB = K + 1;
    localparam int AW = 5;
    localparam int SW = 2;
    localparam int MAXW = 32;

    typedef struct packed {
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        logic          last;
    } win_t;

    logic          clk_i = 1'b0;
    logic          resetn_i;
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] image_dimension;
    logic          pixel_valid_i;
    logic          pixel_ready_o;
    logic [NB-1:0] buf_we_o;
    logic          buf_clear_n_o;
    logic [AW-1:0] read_address_o;
    logic [SW-1:0] row_sel_o;
    logic          window_valid_o;
    logic          window_ready_i;
    logic [AW-1:0] window_row_o;
    logic [AW-1:0] window_col_o;
    logic          window_last_o;
    logic          frame_done_o;
    logic          busy_o;
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0]   in_stall_cnt_o;
    logic [15:0]   out_stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    win_t exp_q[$];

    // Observations collected by run_frame for the scenario tasks.
    int r_pix, r_wins, r_first_valid, r_line_k_cyc, r_last_hs, r_done_cyc;
    int r_pix_at_lowend, r_hs3_cyc, r_sim_cyc;
    int r_lines_before, r_lines_after, r_wsel_before, r_wsel_after, r_rsel_before, r_rsel_after;
    logic r_rdy_hs3, r_rdy_after_hs3;
    bit r_sim_seen;

    conv_window_ctrl #(.KERNEL_WIDTH(K), .MAX_LINE_WIDTH(MAXW)) dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .image_dimension (image_dimension),
        .pixel_valid_i   (pixel_valid_i),
        .pixel_ready_o   (pixel_ready_o),
        .buf_we_o        (buf_we_o),
        .buf_clear_n_o   (buf_clear_n_o),
        .read_address_o  (read_address_o),
        .row_sel_o       (row_sel_o),
        .window_valid_o  (window_valid_o),
        .window_ready_i  (window_ready_i),
        .window_row_o    (window_row_o),
        .window_col_o    (window_col_o),
        .window_last_o   (window_last_o),
        .frame_done_o    (frame_done_o),
        .busy_o          (busy_o)
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        ,
        .in_stall_cnt_o  (in_stall_cnt_o),
        .out_stall_cnt_o (out_stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog expired at time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Pulse start for one edge; queue the expected windows if the dimension is legal.
    task automatic do_start(input int d);
        win_t e;
        @(negedge clk_i);
        image_dimension = AW'(d);
        start_i = 1'b1;
        if (d >= K && d <= MAXW) begin
            for (int r = 0; r <= d - K; r++) begin
                for (int c = 0; c <= d - K; c++) begin
                    e.row  = AW'(r);
                    e.col  = AW'(c);
                    e.last = (r == d - K) && (c == d - K);
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Pixels offered every cycle; window_ready_i low for the first rdy_low cycles.
    task automatic run_frame(input int d, input int rdy_low, input int max_cyc, input bit expect_done);
        int hs;
        win_t e;
        logic [NB-1:0] exp_we;
        r_pix = 0; r_wins = 0; r_first_valid = -1; r_line_k_cyc = -1; r_last_hs = -1; r_done_cyc = -1;
        r_pix_at_lowend = -1; r_hs3_cyc = -1; r_sim_cyc = -1; r_sim_seen = 0;
        r_rdy_hs3 = 1'bx; r_rdy_after_hs3 = 1'bx;
        hs = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk_i);
            pixel_valid_i  = 1'b1;
            window_ready_i = (cyc >= rdy_low);
            #1;
            if (cyc == rdy_low) r_pix_at_lowend = r_pix;
            if (r_hs3_cyc >= 0 && cyc == r_hs3_cyc + 1) r_rdy_after_hs3 = pixel_ready_o;
            if (r_sim_seen && cyc == r_sim_cyc + 1) begin
                r_lines_after = int'(dut.lines_q);
                r_wsel_after  = int'(dut.wr_sel_q);
                r_rsel_after  = int'(row_sel_o);
            end
            if (frame_done_o) begin
                r_done_cyc = cyc;
                break;
            end
            if (window_valid_o && r_first_valid < 0) r_first_valid = cyc;
            if (buf_we_o != '0) begin
                exp_we = NB'(1) << ((r_pix / d) % NB);
                checks++;
                if (buf_we_o !== exp_we) begin
                    failures++;
                    $display("FAIL buf_we pixel=%0d got=%b expected=%b", r_pix, buf_we_o, exp_we);
                end
                r_pix++;
                if (r_pix == K * d) r_line_k_cyc = cyc;
            end
            if (window_valid_o && window_ready_i) begin
                hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL window_extra got row=%0d col=%0d expected no window", window_row_o, window_col_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({window_row_o, window_col_o, window_last_o, read_address_o, row_sel_o} !==
                        {e.row, e.col, e.last, e.col, SW'(e.row % NB)}) begin
                        failures++;
                        $display("FAIL window_order got row=%0d col=%0d last=%0b addr=%0d sel=%0d expected row=%0d col=%0d last=%0b addr=%0d sel=%0d",
                                 window_row_o, window_col_o, window_last_o, read_address_o, row_sel_o,
                                 e.row, e.col, e.last, e.col, e.row % NB);
                    end
                end
                r_wins++;
                if (window_last_o) r_last_hs = cyc;
                if (hs == 3) begin
                    r_hs3_cyc = cyc;
                    r_rdy_hs3 = pixel_ready_o;
                end
                if (buf_we_o != '0 && ((r_pix - 1) % d) == d - 1 && int'(window_col_o) == d - K) begin
                    r_sim_seen     = 1;
                    r_sim_cyc      = cyc;
                    r_lines_before = int'(dut.lines_q);
                    r_wsel_before  = int'(dut.wr_sel_q);
                    r_rsel_before  = int'(row_sel_o);
                end
            end
        end
        pixel_valid_i  = 1'b0;
        window_ready_i = 1'b0;
        checks++;
        if (expect_done && r_done_cyc < 0) begin
            failures++;
            $display("FAIL frame_timeout got no frame_done in %0d cycles expected frame_done", max_cyc);
        end else if (!expect_done && r_done_cyc >= 0) begin
            failures++;
            $display("FAIL frame_done_early got frame_done at cycle %0d expected none", r_done_cyc);
        end
    endtask

    task automatic test_reset;
        logic [26:0] obs;
        resetn_i = 1'b0;
        image_dimension = AW'(5);
        start_i = 1'b1;
        @(negedge clk_i);
        #1;
        obs = {pixel_ready_o, buf_we_o, buf_clear_n_o, read_address_o, row_sel_o, window_valid_o,
               window_row_o, window_col_o, window_last_o, frame_done_o, busy_o};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", obs);
        end
        start_i = 1'b0;
        resetn_i = 1'b1;
        @(negedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b expected=0", busy_o);
        end
    endtask

    task automatic test_basic;
        do_start(5);
        run_frame(5, 0, 200, 1);
        checks++;
        if (r_pix != 25 || r_wins != 9) begin
            failures++;
            $display("FAIL basic_counts got pixels=%0d windows=%0d expected 25 and 9", r_pix, r_wins);
        end
        checks++;
        if (r_first_valid - r_line_k_cyc != 1) begin
            failures++;
            $display("FAIL basic_first_window_latency got=%0d expected=1", r_first_valid - r_line_k_cyc);
        end
        checks++;
        if (r_done_cyc - r_last_hs != 1) begin
            failures++;
            $display("FAIL basic_done_latency got=%0d expected=1", r_done_cyc - r_last_hs);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_missing_windows got=%0d left expected=0", exp_q.size());
        end
        checks++;
        if ({busy_o, frame_done_o} !== 2'b11) begin
            failures++;
            $display("FAIL basic_done_state got busy=%b done=%b expected 1 1", busy_o, frame_done_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if ({busy_o, frame_done_o} !== 2'b00) begin
            failures++;
            $display("FAIL basic_idle_after got busy=%b done=%b expected 0 0", busy_o, frame_done_o);
        end
    endtask

    task automatic test_back_to_back;
        do_start(3);
        run_frame(3, 0, 100, 1);
        checks++;
        if (r_pix != 9 || r_wins != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back got pixels=%0d windows=%0d left=%0d expected 9 1 0", r_pix, r_wins, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        do_start(5);
        run_frame(5, 30, 300, 1);
        checks++;
        if (r_pix_at_lowend != 20) begin
            failures++;
            $display("FAIL bp_pixels_before_stall got=%0d expected=20", r_pix_at_lowend);
        end
        checks++;
        if (r_rdy_hs3 !== 1'b0 || r_rdy_after_hs3 !== 1'b1) begin
            failures++;
            $display("FAIL bp_reopen got ready_at_hs3=%b ready_after=%b expected 0 1", r_rdy_hs3, r_rdy_after_hs3);
        end
        checks++;
        if (r_pix != 25 || r_wins != 9 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_counts got pixels=%0d windows=%0d left=%0d expected 25 9 0", r_pix, r_wins, exp_q.size());
        end
    endtask

    task automatic test_bad_dim;
        int dims[2];
        dims[0] = 2;
        dims[1] = 33;
        foreach (dims[i]) begin
            do_start(dims[i]);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                pixel_valid_i = 1'b1;
                #1;
                checks++;
                if (busy_o !== 1'b0 || buf_we_o !== '0) begin
                    failures++;
                    $display("FAIL bad_dim d=%0d got busy=%b we=%b expected 0 0", dims[i], busy_o, buf_we_o);
                end
            end
            pixel_valid_i = 1'b0;
        end
    endtask

    task automatic test_simultaneous;
        do_start(4);
        run_frame(4, 14, 200, 1);
        checks++;
        if (!r_sim_seen) begin
            failures++;
            $display("FAIL sim_event got no coincident line end and row release expected one");
        end else begin
            if (r_lines_before != r_lines_after) begin
                failures++;
                $display("FAIL sim_lines got before=%0d after=%0d expected equal", r_lines_before, r_lines_after);
            end
            checks++;
            if (r_wsel_after != (r_wsel_before + 1) % NB || r_rsel_after != (r_rsel_before + 1) % NB) begin
                failures++;
                $display("FAIL sim_sel_advance got wr_sel %0d->%0d row_sel %0d->%0d expected both +1 mod %0d",
                         r_wsel_before, r_wsel_after, r_rsel_before, r_rsel_after, NB);
            end
        end
        checks++;
        if (r_wins != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sim_windows got=%0d left=%0d expected 4 0", r_wins, exp_q.size());
        end
    endtask

    task automatic check_after_cancel(input string tag);
        logic [26:0] obs;
        obs = {pixel_ready_o, buf_we_o, buf_clear_n_o, read_address_o, row_sel_o, window_valid_o,
               window_row_o, window_col_o, window_last_o, frame_done_o, busy_o};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL %s_outputs got=%h expected=0", tag, obs);
        end
    endtask

    task automatic test_abort;
        do_start(5);
        run_frame(5, 0, 17, 0);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        exp_q.delete();
        check_after_cancel("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done got done=%b busy=%b expected 0 0", frame_done_o, busy_o);
            end
        end
        do_start(3);
        run_frame(3, 0, 100, 1);
        checks++;
        if (r_wins != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_restart got windows=%0d left=%0d expected 1 0", r_wins, exp_q.size());
        end
    endtask

    task automatic test_async_reset;
        do_start(5);
        run_frame(5, 0, 17, 0);
        #2 resetn_i = 1'b0;
        #1;
        exp_q.delete();
        check_after_cancel("async_reset");
        @(negedge clk_i);
        resetn_i = 1'b1;
        #1;
        checks++;
        if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_idle got done=%b busy=%b expected 0 0", frame_done_o, busy_o);
        end
        do_start(3);
        run_frame(3, 0, 100, 1);
        checks++;
        if (r_wins != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL async_reset_restart got windows=%0d left=%0d expected 1 0", r_wins, exp_q.size());
        end
    endtask

`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    task automatic test_stall_cnt;
        do_start(5);
        run_frame(5, 22, 300, 1);
        checks++;
        if (out_stall_cnt_o !== 16'd7) begin
            failures++;
            $display("FAIL out_stall_cnt got=%0d expected=7", out_stall_cnt_o);
        end
        checks++;
        if (in_stall_cnt_o !== 16'd8) begin
            failures++;
            $display("FAIL in_stall_cnt got=%0d expected=8", in_stall_cnt_o);
        end
    endtask
`endif

    initial begin
        resetn_i        = 1'b0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        image_dimension = '0;
        pixel_valid_i   = 1'b0;
        window_ready_i  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_bad_dim();
        test_simultaneous();
        test_abort();
        test_async_reset();
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencing controller for a bank of `KERNEL_WIDTH+1` single-line pixel buffers, forming the sliding-window front end of the CNN convolution datapath.
- Accepts a raster pixel stream and steers each pixel into one free line buffer.
- Tracks which buffers hold complete lines and drives the shared buffer read address.
- Emits one `KERNEL_WIDTH`×`KERNEL_WIDTH` window position per handshake to the downstream MAC array.
- Applies backpressure upstream when no line buffer is free.

## Interface
- `KERNEL_WIDTH`, 3, window side; number of buffers `NB = KERNEL_WIDTH+1`.
- `MAX_LINE_WIDTH`, 32, maximum image side; `AW = $clog2(MAX_LINE_WIDTH)`.
- `clk_i` in 1: single clock; all state on rising edge.
- `resetn_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin frame; sampled only in IDLE.
- `abort_i` in 1: cancel current frame.
- `image_dimension` in AW: square image side; latched on accepted start.
- `pixel_valid_i` in 1 / `pixel_ready_o` out 1: input pixel handshake.
- `buf_we_o` out NB: one-hot data-valid to line buffer `wr_sel`; equals `pixel_valid_i && pixel_ready_o`.
- `buf_clear_n_o` out 1: synchronous clear to all buffers; low in IDLE.
- `read_address_o` out AW: shared window column address to all buffers.
- `row_sel_o` out `$clog2(NB)`: index of the buffer holding the window's top row. Row r of the window is buffer `(row_sel_o+r) mod NB`.
- `window_valid_o` out 1 / `window_ready_i` in 1: window handshake. Window data is valid combinationally from the buffers in the same cycle.
- `window_row_o`, `window_col_o` out AW: output coordinates of the current window.
- `window_last_o` out 1: high on the final window of the frame.
- `frame_done_o` out 1: single-cycle pulse.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- States and transitions:
  - IDLE → ACTIVE on `start_i` when `KERNEL_WIDTH ≤ image_dimension ≤ MAX_LINE_WIDTH`. Otherwise `start_i` is ignored.
  - ACTIVE → DONE on window handshake with `window_last_o`.
  - DONE → IDLE unconditionally (one cycle, `frame_done_o`=1).
  - `abort_i` in ACTIVE/DONE → IDLE next cycle; no `frame_done_o`. Abort has priority over every other event.
- Write side (latched dimension D):
  - `wr_col` counts 0..D-1. On a write with `wr_col==D-1`: `wr_col←0`, `wr_sel←(wr_sel+1) mod NB`, `lines` increments.
  - `wr_pix` counts accepted pixels; once D·D have been accepted, `pixel_ready_o` stays 0 for the rest of the frame.
  - `pixel_ready_o = ACTIVE && lines < NB && wr_pix < D·D`.
- Read side:
  - `window_valid_o = ACTIVE && lines ≥ KERNEL_WIDTH`.
  - `read_address_o = rd_col`, with `rd_col` in 0..D-KERNEL_WIDTH.
  - On a handshake at `rd_col==D-KERNEL_WIDTH`: `rd_col←0`, `row_sel_o←(row_sel_o+1) mod NB`, `lines` decrements, `window_row_o` increments.
  - `window_col_o` tracks `rd_col`.
- A line completion and a row release in the same cycle leave `lines` unchanged.
- `lines` never exceeds NB; the write buffer is never among the KERNEL_WIDTH buffers being read.
- `window_last_o = (window_row_o==D-KERNEL_WIDTH) && (rd_col==D-KERNEL_WIDTH)`.
- Output windows per frame: (D-K+1)².
- Entering IDLE (reset, DONE, abort) zeroes `wr_col`, `wr_pix`, `rd_col`, `wr_sel`, `row_sel_o`, `lines`, and both coordinates.

## Timing
- Reset values: `pixel_ready_o`, `buf_we_o`, `buf_clear_n_o`, `read_address_o`, `row_sel_o`, `window_valid_o`, coordinates, `window_last_o`, `frame_done_o`, `busy_o` are all 0.
- Start: `start_i` at edge n; `busy_o`, `buf_clear_n_o`, `pixel_ready_o` go high after edge n.
- Buffer write: the buffer captures a pixel on the edge where `buf_we_o` is high.
- First window: `window_valid_o` rises in the cycle after the edge that writes the last pixel of line K-1. Pixel-to-window latency is 1 cycle.
- Window handshake: each handshake advances the position at that edge. With `window_ready_i` tied high, throughput is one window per cycle.
- Frame end: `frame_done_o` is high in the cycle after the last window handshake.
- Restart: IDLE is reached one cycle after DONE, so the earliest restart `start_i` is sampled then.
- Registers: all counters and flags are registered. `pixel_ready_o`, `window_valid_o`, `buf_we_o` and `window_last_o` are combinational from registers and inputs.

## Configuration
- `CONV_WINDOW_CTRL_STALL_CNT_EN` defined adds 16-bit saturating outputs `in_stall_cnt_o` and `out_stall_cnt_o`:
  - `in_stall_cnt_o` counts ACTIVE cycles with `pixel_valid_i && !pixel_ready_o`.
  - `out_stall_cnt_o` counts ACTIVE cycles with `window_valid_o && !window_ready_i`.
  - Both reset to 0 on reset and on accepted start.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- K=3, D=5, continuous valid/ready: 25 pixels accepted, 9 windows in order (row,col) (0,0)..(2,2), `read_address_o` sequence 0,1,2; `window_last_o` only on (2,2); `frame_done_o` one cycle later.
- D=5, `window_ready_i`=0: `pixel_ready_o` drops after exactly 20 pixels (lines=4); releasing ready for 3 handshakes reopens input.
- `start_i` with D=2 or D=33 (MAX=32): stays IDLE, `busy_o`=0, no `buf_we_o`.
- Simultaneous line-end write and row-release handshake at D=4: `lines` stays constant; `wr_sel` and `row_sel_o` both advance.
- `abort_i` mid-frame, and asynchronous `resetn_i` low mid-frame: outputs return to reset values, no `frame_done_o`; next start at D=3 yields exactly 1 window.
- With macro: D=5, ready low for 7 ACTIVE valid cycles → `out_stall_cnt_o`=7.
